// File: rtl/memory_sdram_arbiter_if.sv
// System clock/reset bundle shared by blocks on the SDRAM side of the design.
interface if_system;
    logic clk;
    logic reset;

    modport dut (
        input clk,
        input reset
    );
endinterface

// File: rtl/memory_sdram_arbiter.sv
// Shares one SDRAM controller port between NUM_PORTS requesters.
// Port 0 has priority, bounded by a streak counter so the other ports
// cannot starve; ports 1..NUM_PORTS-1 are served round-robin.
//
// Handshake: a requester raises port_request[i] with write/address/wdata
// stable and holds it until port_ack[i] pulses for one cycle; that pulse is
// the completion (write issued, or port_rdata valid). Towards the controller,
// mem_request stays high with stable write/address/wdata until mem_ack, and
// is dropped at the edge that ends the mem_ack cycle. Only one transaction
// is ever outstanding.
module memory_sdram_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int MAX_STREAK = 8
) (
    if_system.dut                         sys,
    input  logic [NUM_PORTS-1:0]          port_request,
    output logic [NUM_PORTS-1:0]          port_ack,
    input  logic [NUM_PORTS-1:0]          port_write,
    input  logic [NUM_PORTS-1:0][31:0]    port_address,
    input  logic [NUM_PORTS-1:0][15:0]    port_wdata,
    output logic [15:0]                   port_rdata,
    output logic                          mem_request,
    input  logic                          mem_ack,
    output logic                          mem_write,
    output logic [31:0]                   mem_address,
    output logic [15:0]                   mem_wdata,
    input  logic [15:0]                   mem_rdata,
    output logic                          busy,
    output logic [2:0]                    grant_id,
    output logic                          dbg_state
);

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_GRANTED = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  grant_q, grant_d;
    logic [2:0]  rr_next_q, rr_next_d;
    logic [7:0]  streak_q, streak_d;
    logic        mem_request_q, mem_request_d;
    logic        busy_q, busy_d;

    logic        any_req;
    logic        others_req;
    logic        port0_wins;
    logic        rr_found;
    logic [2:0]  rr_winner;
    logic [2:0]  winner;
    logic [3:0]  rr_sum;
    logic [2:0]  rr_cand;

    // Winner selection: port 0 unless its streak is exhausted while others
    // wait; otherwise the first requesting port at or after rr_next.
    always_comb begin
        any_req    = |port_request;
        others_req = |port_request[NUM_PORTS-1:1];
        port0_wins = port_request[0] && ((streak_q < 8'(MAX_STREAK)) || !others_req);
        rr_found   = 1'b0;
        rr_winner  = 3'd1;
        rr_sum     = 4'd0;
        rr_cand    = 3'd1;
        for (int i = 0; i < NUM_PORTS - 1; i++) begin
            rr_sum = {1'b0, rr_next_q} + 4'(i);
            if (rr_sum > 4'(NUM_PORTS - 1)) begin
                rr_sum = rr_sum - 4'(NUM_PORTS - 1);
            end
            rr_cand = rr_sum[2:0];
            for (int j = 1; j < NUM_PORTS; j++) begin
                if (!rr_found && (rr_cand == 3'(j)) && port_request[j]) begin
                    rr_found  = 1'b1;
                    rr_winner = 3'(j);
                end
            end
        end
        winner = port0_wins ? 3'd0 : rr_winner;
    end

    // Next-state logic: grant on any request in idle, release on mem_ack.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        rr_next_d     = rr_next_q;
        streak_d      = streak_q;
        mem_request_d = mem_request_q;
        busy_d        = busy_q;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    state_d       = S_GRANTED;
                    grant_d       = winner;
                    mem_request_d = 1'b1;
                    busy_d        = 1'b1;
                    if (winner == 3'd0) begin
                        if (others_req) begin
                            if (streak_q < 8'(MAX_STREAK)) begin
                                streak_d = streak_q + 8'd1;
                            end
                        end else begin
                            streak_d = 8'd0;
                        end
                    end else begin
                        streak_d  = 8'd0;
                        rr_next_d = (winner == 3'(NUM_PORTS - 1)) ? 3'd1 : winner + 3'd1;
                    end
                end
            end
            S_GRANTED: begin
                if (mem_ack) begin
                    state_d       = S_IDLE;
                    mem_request_d = 1'b0;
                    busy_d        = 1'b0;
                end
            end
            default: begin
                state_d       = S_IDLE;
                mem_request_d = 1'b0;
                busy_d        = 1'b0;
            end
        endcase
    end

    // State register; reset abandons any grant in flight.
    always_ff @(posedge sys.clk) begin
        if (sys.reset) begin
            state_q       <= S_IDLE;
            grant_q       <= 3'd0;
            rr_next_q     <= 3'd1;
            streak_q      <= 8'd0;
            mem_request_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            rr_next_q     <= rr_next_d;
            streak_q      <= streak_d;
            mem_request_q <= mem_request_d;
            busy_q        <= busy_d;
        end
    end

    // Controller-side mux from the registered grant, and the per-port ack.
    always_comb begin
        mem_write   = 1'b0;
        mem_address = 32'd0;
        mem_wdata   = 16'd0;
        port_ack    = '0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            if (grant_q == 3'(j)) begin
                mem_write   = port_write[j];
                mem_address = port_address[j];
                mem_wdata   = port_wdata[j];
                port_ack[j] = (state_q == S_GRANTED) && mem_ack;
            end
        end
    end

    assign port_rdata  = mem_rdata;
    assign mem_request = mem_request_q;
    assign busy        = busy_q;
    assign grant_id    = grant_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_memory_sdram_arbiter.sv
// Directed bench for memory_sdram_arbiter with a simple controller model.
module tb_memory_sdram_arbiter;
    localparam int NP = 4;

    if_system sys();

    logic [NP-1:0]       port_request;
    logic [NP-1:0]       port_ack;
    logic [NP-1:0]       port_write;
    logic [NP-1:0][31:0] port_address;
    logic [NP-1:0][15:0] port_wdata;
    logic [15:0]         port_rdata;
    logic                mem_request;
    logic                mem_ack;
    logic                mem_write;
    logic [31:0]         mem_address;
    logic [15:0]         mem_wdata;
    logic [15:0]         mem_rdata;
    logic                busy;
    logic [2:0]          grant_id;
    logic                dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    logic          t_ok;
    logic [2:0]    t_gid;
    logic [31:0]   t_addr;
    logic          t_write;
    logic [15:0]   t_wdata;
    logic [NP-1:0] t_ack;
    logic [15:0]   t_prdata;

    memory_sdram_arbiter #(.NUM_PORTS(NP), .MAX_STREAK(8)) dut (
        .sys          (sys),
        .port_request (port_request),
        .port_ack     (port_ack),
        .port_write   (port_write),
        .port_address (port_address),
        .port_wdata   (port_wdata),
        .port_rdata   (port_rdata),
        .mem_request  (mem_request),
        .mem_ack      (mem_ack),
        .mem_write    (mem_write),
        .mem_address  (mem_address),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .busy         (busy),
        .grant_id     (grant_id),
        .dbg_state    (dbg_state)
    );

    // Clock and reset
    initial sys.clk = 1'b0;
    always #5 sys.clk = ~sys.clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge sys.clk);
        #1;
    endtask

    task automatic apply_reset();
        sys.reset    = 1'b1;
        port_request = '0;
        port_write   = '0;
        port_address = '0;
        port_wdata   = '0;
        mem_ack      = 1'b0;
        mem_rdata    = 16'd0;
        repeat (2) tick();
        sys.reset = 1'b0;
    endtask

    // Controller model: wait for mem_request, ack after 'latency' cycles.
    // Returns at #1 into the cycle after the ack.
    task automatic do_txn(input int latency, input logic [15:0] rdata);
        t_ok  = 1'b0;
        t_gid = 3'd7;
        t_ack = '0;
        for (int i = 0; i < 20; i++) begin
            if (mem_request) begin
                t_ok = 1'b1;
                break;
            end
            tick();
        end
        n_checks++;
        if (!t_ok) $display("FAIL txn_timeout: mem_request=0 after 20 cycles, required 1");
        else n_pass++;
        if (t_ok) begin
            t_gid   = grant_id;
            t_addr  = mem_address;
            t_write = mem_write;
            t_wdata = mem_wdata;
            repeat (latency) tick();
            mem_rdata = rdata;
            mem_ack   = 1'b1;
            #1;
            t_ack    = port_ack;
            t_prdata = port_rdata;
            tick();
            mem_ack   = 1'b0;
            mem_rdata = 16'd0;
        end
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++; if (mem_request !== 1'b0) $display("FAIL reset_mem_request: got %b want 0", mem_request); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (grant_id !== 3'd0) $display("FAIL reset_grant_id: got %0d want 0", grant_id); else n_pass++;
        n_checks++; if (port_ack !== 4'b0000) $display("FAIL reset_port_ack: got %b want 0000", port_ack); else n_pass++;
        n_checks++; if (dbg_state !== 1'b0) $display("FAIL reset_state: got %b want 0", dbg_state); else n_pass++;
    endtask

    task automatic test_single_read();
        apply_reset();
        port_address[2] = 32'h0000_1000;
        port_write[2]   = 1'b0;
        port_request[2] = 1'b1;
        #1;
        n_checks++; if (mem_request !== 1'b0) $display("FAIL read_req_cycle_t: got %b want 0", mem_request); else n_pass++;
        tick();
        n_checks++; if (mem_request !== 1'b1) $display("FAIL read_req_latency: got %b want 1", mem_request); else n_pass++;
        n_checks++; if (grant_id !== 3'd2) $display("FAIL read_grant: got %0d want 2", grant_id); else n_pass++;
        n_checks++; if (mem_address !== 32'h0000_1000) $display("FAIL read_addr: got %h want 00001000", mem_address); else n_pass++;
        n_checks++; if (mem_write !== 1'b0) $display("FAIL read_write: got %b want 0", mem_write); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL read_busy: got %b want 1", busy); else n_pass++;
        do_txn(3, 16'hBEEF);
        port_request[2] = 1'b0;
        n_checks++; if (t_ack !== 4'b0100) $display("FAIL read_port_ack: got %b want 0100", t_ack); else n_pass++;
        n_checks++; if (t_prdata !== 16'hBEEF) $display("FAIL read_rdata: got %h want beef", t_prdata); else n_pass++;
        n_checks++; if (mem_request !== 1'b0) $display("FAIL read_req_drop: got %b want 0", mem_request); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL read_busy_drop: got %b want 0", busy); else n_pass++;
        n_checks++; if (port_ack !== 4'b0000) $display("FAIL read_ack_after: got %b want 0000", port_ack); else n_pass++;
        tick();
        n_checks++; if (mem_request !== 1'b0) $display("FAIL read_no_regrant: got %b want 0", mem_request); else n_pass++;
    endtask

    task automatic test_idle_ack();
        mem_ack = 1'b1;
        #1;
        n_checks++; if (port_ack !== 4'b0000) $display("FAIL idle_ack_port_ack: got %b want 0000", port_ack); else n_pass++;
        tick();
        mem_ack = 1'b0;
        n_checks++; if (mem_request !== 1'b0) $display("FAIL idle_ack_mem_request: got %b want 0", mem_request); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL idle_ack_busy: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_gid;
        apply_reset();
        port_request = 4'b1110;
        for (int k = 0; k < 6; k++) begin
            exp_gid = 3'((k % 3) + 1);
            do_txn(1, 16'h1000 + 16'(k));
            n_checks++; if (t_gid !== exp_gid) $display("FAIL rr_grant_%0d: got %0d want %0d", k, t_gid, exp_gid); else n_pass++;
            n_checks++; if (t_ack !== (4'b0001 << exp_gid)) $display("FAIL rr_ack_%0d: got %b want %b", k, t_ack, 4'b0001 << exp_gid); else n_pass++;
        end
        port_request = '0;
        tick();
    endtask

    task automatic test_starvation();
        logic [2:0] exp_gid;
        apply_reset();
        port_request = 4'b1001;
        for (int k = 0; k < 18; k++) begin
            exp_gid = ((k % 9) == 8) ? 3'd3 : 3'd0;
            do_txn(1, 16'h2000);
            n_checks++; if (t_gid !== exp_gid) $display("FAIL streak_grant_%0d: got %0d want %0d", k, t_gid, exp_gid); else n_pass++;
        end
        port_request = '0;
        tick();
    endtask

    task automatic test_priority();
        apply_reset();
        port_request = 4'b0011;
        do_txn(2, 16'h3333);
        port_request[0] = 1'b0;
        n_checks++; if (t_gid !== 3'd0) $display("FAIL prio_first: got %0d want 0", t_gid); else n_pass++;
        n_checks++; if (t_ack !== 4'b0001) $display("FAIL prio_first_ack: got %b want 0001", t_ack); else n_pass++;
        n_checks++; if (mem_request !== 1'b0) $display("FAIL prio_gap: got %b want 0", mem_request); else n_pass++;
        tick();
        n_checks++; if (mem_request !== 1'b1) $display("FAIL prio_second_req: got %b want 1", mem_request); else n_pass++;
        n_checks++; if (grant_id !== 3'd1) $display("FAIL prio_second_grant: got %0d want 1", grant_id); else n_pass++;
        do_txn(1, 16'h4444);
        port_request = '0;
        n_checks++; if (t_ack !== 4'b0010) $display("FAIL prio_second_ack: got %b want 0010", t_ack); else n_pass++;
        tick();
    endtask

    task automatic test_write_mux();
        apply_reset();
        port_address[1] = 32'h0200_0010;
        port_write[1]   = 1'b1;
        port_wdata[1]   = 16'h1234;
        port_address[3] = 32'h0000_0020;
        port_write[3]   = 1'b0;
        port_wdata[3]   = 16'h5A5A;
        port_request    = 4'b1010;
        do_txn(2, 16'h0000);
        port_request[1] = 1'b0;
        n_checks++; if (t_gid !== 3'd1) $display("FAIL wmux_grant1: got %0d want 1", t_gid); else n_pass++;
        n_checks++; if (t_addr !== 32'h0200_0010) $display("FAIL wmux_addr1: got %h want 02000010", t_addr); else n_pass++;
        n_checks++; if (t_write !== 1'b1) $display("FAIL wmux_write1: got %b want 1", t_write); else n_pass++;
        n_checks++; if (t_wdata !== 16'h1234) $display("FAIL wmux_wdata1: got %h want 1234", t_wdata); else n_pass++;
        do_txn(2, 16'h7777);
        port_request = '0;
        n_checks++; if (t_gid !== 3'd3) $display("FAIL wmux_grant3: got %0d want 3", t_gid); else n_pass++;
        n_checks++; if (t_addr !== 32'h0000_0020) $display("FAIL wmux_addr3: got %h want 00000020", t_addr); else n_pass++;
        n_checks++; if (t_write !== 1'b0) $display("FAIL wmux_write3: got %b want 0", t_write); else n_pass++;
        n_checks++; if (t_wdata !== 16'h5A5A) $display("FAIL wmux_wdata3: got %h want 5a5a", t_wdata); else n_pass++;
        n_checks++; if (t_ack !== 4'b1000) $display("FAIL wmux_ack3: got %b want 1000", t_ack); else n_pass++;
        n_checks++; if (t_prdata !== 16'h7777) $display("FAIL wmux_rdata3: got %h want 7777", t_prdata); else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid_grant();
        apply_reset();
        port_request = 4'b0010;
        do_txn(1, 16'h0001);
        port_request = 4'b0100;
        tick();
        n_checks++; if (grant_id !== 3'd2) $display("FAIL midrst_pre_grant: got %0d want 2", grant_id); else n_pass++;
        n_checks++; if (mem_request !== 1'b1) $display("FAIL midrst_pre_req: got %b want 1", mem_request); else n_pass++;
        sys.reset = 1'b1;
        tick();
        n_checks++; if (mem_request !== 1'b0) $display("FAIL midrst_req: got %b want 0", mem_request); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (grant_id !== 3'd0) $display("FAIL midrst_grant: got %0d want 0", grant_id); else n_pass++;
        n_checks++; if (port_ack !== 4'b0000) $display("FAIL midrst_ack: got %b want 0000", port_ack); else n_pass++;
        sys.reset    = 1'b0;
        port_request = 4'b1010;
        do_txn(1, 16'h0002);
        port_request = '0;
        n_checks++; if (t_gid !== 3'd1) $display("FAIL midrst_rr_restart: got %0d want 1", t_gid); else n_pass++;
        tick();
    endtask

    // Test sequence and final report
    initial begin
        sys.reset = 1'b1;
        test_reset();
        test_single_read();
        test_idle_ack();
        test_round_robin();
        test_starvation();
        test_priority();
        test_write_mux();
        test_reset_mid_grant();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/memory_sdram_arbiter.md
# memory_sdram_arbiter

Shares the single SDRAM controller memory port (request/ack/write/address/wdata/rdata) between NUM_PORTS requesters. Examples are the N64 PI bus, USB DMA, SD DMA and the CPU. Port 0 is the latency-critical port and has priority, with a starvation guard. The remaining ports are served round-robin. The block sits between the bus/DMA masters and the SDRAM controller, and holds one outstanding transaction at a time.

## Interface
- NUM_PORTS, 4: number of requesters, 2..8; port 0 is the priority port.
- MAX_STREAK, 8: maximum consecutive port-0 grants while any other port is pending, 1..255.
- sys.clk  input  1  system clock (if_system sys).
- sys.reset  input  1  reset, synchronous, active-high (if_system sys).
- port_request  input  NUM_PORTS  per-port request; held high until that port's ack.
- port_ack  output  NUM_PORTS  per-port one-cycle completion pulse.
- port_write  input  NUM_PORTS  1 = write, 0 = read; stable while request is high.
- port_address  input  NUM_PORTS x 32  byte address; stable while request is high.
- port_wdata  input  NUM_PORTS x 16  write data; stable while request is high.
- port_rdata  output  16  read data, broadcast to all ports; valid only with that port's ack.
- mem_request  output  1  request to the SDRAM controller.
- mem_ack  input  1  controller ack: write issued, or read data valid this cycle.
- mem_write  output  1  muxed write flag.
- mem_address  output  32  muxed address.
- mem_wdata  output  16  muxed write data.
- mem_rdata  input  16  controller read data.
- busy  output  1  high while a grant is held.
- grant_id  output  3  index of the port currently or last granted.

## Operation
- States:
  - S_IDLE: arbitrate each cycle on port_request.
  - S_GRANTED: mem_request = 1, waiting for mem_ack.
- S_IDLE -> S_GRANTED when any port_request is high. grant_id is registered with the winner, mem_request <= 1, busy <= 1.
- S_GRANTED -> S_IDLE on mem_ack.
  - mem_request <= 0 and busy <= 0 at the same edge, so the controller never sees a stale request in the following cycle.
  - port_ack[grant_id] = mem_ack (combinational); other port_ack bits are 0.
- Mux: mem_write, mem_address and mem_wdata are selected combinationally from the registered grant_id. port_rdata = mem_rdata.
- Winner selection, evaluated in S_IDLE:
  - If port 0 requests and (streak < MAX_STREAK, or no other port requests), port 0 wins.
  - Otherwise the round-robin winner among ports 1..NUM_PORTS-1 wins. The search starts at rr_next and wraps from NUM_PORTS-1 to 1.
  - After a non-zero port wins, rr_next = winner+1 (wrapping to 1).
- Streak counter, 8 bit:
  - +1 on a port-0 grant while any other port is requesting.
  - Cleared on any non-zero grant.
  - Cleared on a port-0 grant with no other port requesting.
  - Saturates at MAX_STREAK.
- A port_request that drops before its ack is a protocol violation. The arbiter ignores the drop and completes the granted transaction.
- A port that re-asserts request in the cycle after its ack starts a new transaction, arbitrated normally.

## Timing
- Reset values:
  - state S_IDLE.
  - mem_request 0, busy 0, grant_id 0.
  - port_ack 0.
  - rr_next 1, streak 0.
- Reset mid-transaction abandons the grant immediately. The issuing master must reissue after reset.
- Arbitration latency: port_request rising at cycle T (state idle) gives mem_request high at T+1.
- Completion: mem_ack at cycle A gives port_ack at A (same cycle), mem_request low at A+1, and the next grant's mem_request high at A+2 at the earliest.
- Back-to-back throughput: one transaction per (controller latency + 2) cycles, because there is one idle arbitration cycle between grants.
- Simultaneous requests: all are resolved in one cycle by the selection rule. There is no pipelining of a second grant.
- mem_ack while in S_IDLE is ignored; no port_ack is generated.

## Test plan
- Single read: port 2 requests address 0x0000_1000, controller acks 3 cycles after mem_request with rdata 0xBEEF -> port_ack[2] in the mem_ack cycle, port_rdata 0xBEEF, mem_request low the next cycle, other acks 0.
- Round-robin: ports 1, 2 and 3 request continuously, port 0 idle -> grant order 1, 2, 3, 1, 2, 3; each is granted exactly once per three transactions.
- Starvation guard: port 0 and port 3 request continuously with MAX_STREAK=8 -> eight port-0 grants, then one port-3 grant, repeating; port 3 latency is bounded.
- Priority: ports 0 and 1 assert in the same idle cycle with streak 0 -> port 0 granted first; port 1 is granted at the arbitration cycle after port 0's ack.
- Write mux: port 1 write to 0x0200_0010 with wdata 0x1234, concurrent with a port 3 read to 0x0000_0020 -> mem_address, mem_write and mem_wdata match the granted port while mem_request is high; no cross-port mixing.
- Reset mid-grant: sys.reset asserted while mem_request is high -> next cycle mem_request 0, busy 0, grant_id 0, port_ack 0; after reset the first arbitration again starts round-robin at port 1.
